// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Holds the controller state encoding and the register-specifier width.
package pipe_ctrl_pkg;

    localparam int REG_W = 3;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage enable/flush controls out.
// master drives the pipeline status; slave is the sequencer.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_halt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_writereg;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_done;
    logic             wb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic             exmem_en;
    logic             memwb_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
               ex_memread, ex_writereg, ex_branch_taken,
               mem_req, mem_done, wb_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, memwb_bubble, halted, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
               ex_memread, ex_writereg, ex_branch_taken,
               mem_req, mem_done, wb_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, memwb_bubble, halted, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use detector: the instruction in ID reads a register a load in EX is writing.
// R0 is compared like any other register.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_writereg,
    output logic             hit
);

    assign hit = ex_memread &
                 ((id_uses_rs & (id_rs == ex_writereg)) |
                  (id_uses_rt & (id_rt == ex_writereg)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: Mealy stage controls,
// registered halt flag and a saturating front-end stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    logic [1:0]       state, state_nxt;
    logic             ret_drain, ret_drain_nxt;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic             lu_hit;
    logic             mem_wait;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic             exmem_en, memwb_bubble;

    hazard_cmp u_hazard_cmp (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rs  (bus.id_uses_rs),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_memread  (bus.ex_memread),
        .ex_writereg (bus.ex_writereg),
        .hit         (lu_hit)
    );

    assign mem_wait = bus.mem_req & ~bus.mem_done;

    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_en       = 1'b1;
        idex_bubble   = 1'b0;
        exmem_en      = 1'b1;
        memwb_bubble  = 1'b0;
        state_nxt     = state;
        ret_drain_nxt = ret_drain;

        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    memwb_bubble  = 1'b1;
                    state_nxt     = ST_MEMWAIT;
                    ret_drain_nxt = 1'b0;
                end else if (bus.ex_branch_taken) begin
                    // Younger ID/IF instructions are wrong-path: halt and load-use are moot.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (lu_hit) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (bus.id_halt) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    state_nxt  = ST_DRAIN;
                end
                if (bus.wb_halt) state_nxt = ST_HALTED;
            end
            ST_MEMWAIT: begin
                if (!bus.mem_done) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    memwb_bubble = 1'b1;
                end else begin
                    state_nxt     = ret_drain ? ST_DRAIN : ST_RUN;
                    ret_drain_nxt = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (mem_wait) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    memwb_bubble  = 1'b1;
                    state_nxt     = ST_MEMWAIT;
                    ret_drain_nxt = 1'b1;
                end else begin
                    // Only older instructions remain; keep the front end empty.
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    if (bus.wb_halt) state_nxt = ST_HALTED;
                end
            end
            default: begin
                {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            ret_drain <= 1'b0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ret_drain <= ret_drain_nxt;
            halted    <= (state_nxt == ST_HALTED);
            if (!pc_en && (state == ST_RUN || state == ST_MEMWAIT) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_en      = idex_en;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_en     = exmem_en;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.halted       = halted;
    assign bus.stall_cnt    = stall_cnt;

endmodule
